// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port SRAM with valid/ready request/response,
// per-lane write masking, one-deep response buffer and clear sweep.
module sram_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NLANES        = DATA_WIDTH / BYTE_WIDTH,
    localparam int DEPTH         = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NLANES-1:0]     req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic                  acc;
    logic                  wr_acc;
    logic                  rd_acc;

    assign acc    = req_valid && req_ready;
    assign wr_acc = acc && req_we;
    assign rd_acc = acc && !req_we;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        unique case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = (CLEAR_ON_RESET != 0);
                if (CLEAR_ON_RESET == 0 || &clear_ptr)
                    state_nxt = RUN;
            end
            RUN: begin
                req_ready = !rsp_valid || rsp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we)
                clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
        end
    end

    // Storage is never reset so contents can survive when no sweep runs.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clear_ptr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NLANES; i++) begin
                if (req_wmask[i])
                    mem[req_addr][i*BYTE_WIDTH +: BYTE_WIDTH]
                        <= req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // A write can only be accepted when any held response is being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (acc)
                rsp_valid <= !req_we;
            else if (rsp_ready)
                rsp_valid <= 1'b0;
            if (rd_acc)
                rsp_rdata <= mem[req_addr];
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl at default width with
// sweep, and at 32 bits with masked lanes and retained contents.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_req_valid, a_req_ready, a_req_we;
    logic [3:0] a_req_addr;
    logic [7:0] a_req_wdata;
    logic [0:0] a_req_wmask;
    logic       a_rsp_valid, a_rsp_ready, a_busy;
    logic [7:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [3:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_wmask;
    logic        b_rsp_valid, b_rsp_ready, b_busy;
    logic [31:0] b_rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    sram_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_we    (a_req_we),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .req_wmask (a_req_wmask),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .busy      (a_busy)
    );

    sram_ctrl #(
        .DATA_WIDTH     (32),
        .CLEAR_ON_RESET (0)
    ) u_dut_w32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (b_req_we),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .req_wmask (b_req_wmask),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .busy      (b_busy)
    );

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic [3:0] ad, input logic [7:0] d);
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = ad;
        a_req_wdata = d;
        a_req_wmask = 1'b1;
        step();
        a_req_valid = 1'b0;
        a_req_we    = 1'b0;
    endtask

    task automatic a_rd(input logic [3:0] ad);
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_addr  = ad;
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic b_wr(input logic [3:0] ad, input logic [31:0] d,
                        input logic [3:0] m);
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = ad;
        b_req_wdata = d;
        b_req_wmask = m;
        step();
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
    endtask

    task automatic b_rd(input logic [3:0] ad);
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        b_req_addr  = ad;
        step();
        b_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nb;
        rst_n       = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
        a_req_wdata = '0;   a_req_wmask = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_wdata = '0;   b_req_wmask = '0; b_rsp_ready = 1'b1;
        #1;
        check_eq("rst_req_ready", 32'(a_req_ready), 0);
        check_eq("rst_rsp_valid", 32'(a_rsp_valid), 0);
        check_eq("rst_rsp_rdata", 32'(a_rsp_rdata), 0);
        check_eq("rst_busy", 32'(a_busy), 1);
        check_eq("rst_b_busy", 32'(b_busy), 1);
        repeat (3) step();
        rst_n = 1'b1;

        n = 0; nb = 0;
        while (n < 64) begin
            step();
            n++;
            if (nb == 0 && !b_busy) nb = n;
            if (!a_busy) break;
        end
        check_eq("sweep_edges", 32'(n), 16);
        check_eq("sweep_ready", 32'(a_req_ready), 1);
        check_eq("noclr_edges", 32'(nb), 1);

        // stream reads of the freshly cleared array
        for (int i = 0; i < 16; i++) begin
            a_req_valid = 1'b1;
            a_req_we    = 1'b0;
            a_req_addr  = 4'(i);
            step();
            check_eq($sformatf("zero_v%0d", i), 32'(a_rsp_valid), 1);
            check_eq($sformatf("zero_d%0d", i), 32'(a_rsp_rdata), 0);
        end
        a_req_valid = 1'b0;

        for (int i = 0; i < 8; i++) a_wr(4'(i), 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) begin
            a_req_valid = 1'b1;
            a_req_we    = 1'b0;
            a_req_addr  = 4'(i);
            step();
            check_eq($sformatf("strm_v%0d", i), 32'(a_rsp_valid), 1);
            check_eq($sformatf("strm_d%0d", i), 32'(a_rsp_rdata),
                     32'(8'h10 + i));
        end
        a_req_valid = 1'b0;
        step();
        check_eq("strm_idle", 32'(a_rsp_valid), 0);
        check_eq("strm_hold", 32'(a_rsp_rdata), 32'h17);

        // backpressure
        a_wr(4'd5, 8'h5A);
        a_wr(4'd6, 8'h66);
        a_rsp_ready = 1'b0;
        a_rd(4'd5);
        a_req_valid = 1'b1;
        a_req_addr  = 4'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_valid", 32'(a_rsp_valid), 1);
            check_eq("bp_data", 32'(a_rsp_rdata), 32'h5A);
            check_eq("bp_ready", 32'(a_req_ready), 0);
        end
        a_rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(a_req_ready), 1);
        step();
        a_req_valid = 1'b0;
        check_eq("bp_next_valid", 32'(a_rsp_valid), 1);
        check_eq("bp_next_data", 32'(a_rsp_rdata), 32'h66);
        step();
        check_eq("bp_drain", 32'(a_rsp_valid), 0);
        check_eq("bp_keep", 32'(a_rsp_rdata), 32'h66);

        // write then read, consecutive edges; write also drops response
        a_rd(4'd1);
        check_eq("ord_pre", 32'(a_rsp_valid), 1);
        a_wr(4'd7, 8'h3C);
        check_eq("ord_wr_novalid", 32'(a_rsp_valid), 0);
        a_rd(4'd7);
        check_eq("ord_valid", 32'(a_rsp_valid), 1);
        check_eq("ord_data", 32'(a_rsp_rdata), 32'h3C);

        // 32-bit lanes
        b_wr(4'd3, 32'hAABBCCDD, 4'b1111);
        b_wr(4'd3, 32'h11223344, 4'b0101);
        b_rd(4'd3);
        check_eq("mask_valid", 32'(b_rsp_valid), 1);
        check_eq("mask_data", b_rsp_rdata, 32'hAA22CC44);
        b_wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        b_rd(4'd3);
        check_eq("mask_zero", b_rsp_rdata, 32'hAA22CC44);

        // reset drops a stalled response, then mid-sweep restart
        a_rsp_ready = 1'b0;
        a_rd(4'd2);
        check_eq("stall_pre", 32'(a_rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(a_rsp_valid), 0);
        check_eq("arst_rdata", 32'(a_rsp_rdata), 0);
        check_eq("arst_busy", 32'(a_busy), 1);
        a_rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (9) step();
        check_eq("mid_busy", 32'(a_busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_addr  = 4'd5;
        n = 0;
        while (n < 64) begin
            step();
            n++;
            if (!a_busy) break;
        end
        check_eq("resweep_edges", 32'(n), 16);
        check_eq("clear_noacc", 32'(a_rsp_valid), 0);
        check_eq("resweep_ready", 32'(a_req_ready), 1);
        step();
        a_req_valid = 1'b0;
        check_eq("late_acc_valid", 32'(a_rsp_valid), 1);
        check_eq("late_acc_data", 32'(a_rsp_rdata), 0);

        // retention without sweep
        b_wr(4'd2, 32'h00000077, 4'b1111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("ret_busy", 32'(b_busy), 0);
        b_rd(4'd2);
        check_eq("ret_data", b_rsp_rdata, 32'h00000077);
        b_rd(4'd3);
        check_eq("ret_data3", b_rsp_rdata, 32'hAA22CC44);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised single-port SRAM block with a valid/ready request/response interface, per-byte write masking, one-deep response buffering and a post-reset clear sweep. It generalises the fixed 16×8 SRAM wrapper to arbitrary depth and width. It gives datapath clients such as the sequence generator a backpressure-safe, known-zero memory after every reset. Storage is a behavioural array inside the block; no external macro is instantiated.

## Interface
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width in bits
- BYTE_WIDTH, 8, write-mask lane width; DATA_WIDTH must be a multiple of it (elaboration error otherwise); NLANES = DATA_WIDTH/BYTE_WIDTH
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents retained across reset
- clk  input  1  sole clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block accepts request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- req_wmask  input  NLANES  per-lane write enable, bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- rsp_valid  output  1  read data available
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  DATA_WIDTH  read data
- busy  output  1  clear sweep in progress

## Operation
- States: CLEAR, RUN. Reset forces CLEAR, clear_ptr = 0, rsp_valid = 0, rsp_rdata = 0.
- CLEAR with CLEAR_ON_RESET=1:
  - Each cycle writes all-zero to mem[clear_ptr] and increments clear_ptr.
  - On the edge that writes DEPTH-1, the state moves to RUN.
- CLEAR with CLEAR_ON_RESET=0: lasts exactly one cycle, performs no write, then moves to RUN.
- busy = (state == CLEAR). req_ready = (state == RUN) && (!rsp_valid || rsp_ready), combinational from registered state.
- Accept: req_valid && req_ready at a rising edge.
- Accepted write:
  - For each lane i with req_wmask[i]=1, that lane of mem[req_addr] takes req_wdata; unmasked lanes are unchanged.
  - Produces no response. An all-zero mask is a legal no-op.
- Accepted read:
  - rsp_rdata <= mem[req_addr] and rsp_valid <= 1.
  - Reflects all writes accepted on earlier edges.
- Response handshake: completes when rsp_valid && rsp_ready at an edge.
  - If no new read is accepted on that edge, rsp_valid <= 0.
  - If a new read is accepted on that edge, rsp_valid stays 1 with the new data.
  - A write accepted on that edge clears rsp_valid.
- Stalled response: while rsp_valid && !rsp_ready, rsp_rdata holds stable and req_ready = 0. Reads and writes both wait, which preserves ordering.
- rsp_rdata is not zeroed when rsp_valid falls; it keeps the last read value.
- Requests presented during CLEAR are not accepted. req_valid may stay high and is accepted once the state is RUN.
- Reset mid-operation (asynchronous):
  - Any pending response is dropped.
  - A partially finished sweep restarts from address 0.
  - With CLEAR_ON_RESET=0, memory contents survive.
- Out-of-range addresses cannot occur, because DEPTH covers the full address space.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, busy 1.
- CLEAR_ON_RESET=1:
  - busy is high for exactly DEPTH rising edges after rst_n deasserts.
  - req_ready can first be 1 after the DEPTH-th edge (16 edges at defaults).
- CLEAR_ON_RESET=0: busy falls after the first edge.
- Read latency is 1 cycle: a read accepted at edge N gives rsp_valid=1 and valid rsp_rdata after edge N.
- Throughput is one request per cycle while rsp_ready=1.
- Write-then-read, same address, consecutive edges: the read returns the new data (no bypass needed; the write lands at the earlier edge).
- There is no simultaneous read and write: one request per cycle, single port.

## Test plan
- Reset then sweep, defaults:
  - Hold rst_n low, release it, count edges -> busy=1 for 16 edges, then req_ready=1.
  - Reading addr 0..15 returns 0x00 each.
- Masked write, DATA_WIDTH=32:
  - Write 0xAABBCCDD mask 4'b1111 to addr 3.
  - Then write 0x11223344 mask 4'b0101 to addr 3.
  - Read addr 3 -> 0xAA22CC44.
- Backpressure:
  - Read addr 5 (holding 0x5A) with rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_rdata=0x5A stable, req_ready=0.
  - Raise rsp_ready -> handshake, then the next request is accepted.
- Streaming: back-to-back reads of addr 0..7 with rsp_ready=1 -> one rsp_valid per cycle, data in order, 1-cycle latency.
- Reset mid-sweep and retention:
  - Assert rst_n low at sweep address 9 -> sweep restarts at 0 and busy lasts a full 16 edges.
  - With CLEAR_ON_RESET=0, write 0x77 to addr 2, reset, read addr 2 -> 0x77.
- Write-read ordering: write 0x3C to addr 7 at edge N and read addr 7 at edge N+1 -> rsp_rdata=0x3C.
